// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the two-port DMEM arbiter.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority + starvation counter.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH = 32;
    localparam int DMEM_DATA_WIDTH = 32;

    typedef enum logic {
        ARB_PORT_CORE = 1'b0,
        ARB_PORT_DBG  = 1'b1
    } arb_port_e;

`ifndef DMEM_ARB_RR_EN
    // Saturating increment used by the port 1 starvation counter.
    function automatic logic [3:0] satInc(input logic [3:0] cnt, input logic [3:0] limit);
        return (cnt == limit) ? cnt : cnt + 4'd1;
    endfunction
`endif

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant logic for the DMEM arbiter: fixed priority with starvation counter,
// or round-robin on last_grant when DMEM_ARB_RR_EN is defined.
module dmem_arb_grant
    import dmem_arbiter_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_p0_valid,
    input  logic i_p1_valid,
    output logic o_grant0,
    output logic o_grant1
);

`ifdef DMEM_ARB_RR_EN

    arb_port_e r_lastGrant;

    // On contention the port that did not win last time gets the slot.
    always_comb begin
        o_grant1 = i_p1_valid && (!i_p0_valid || (r_lastGrant == ARB_PORT_CORE));
        o_grant0 = i_p0_valid && !o_grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= ARB_PORT_DBG;
        end else if (o_grant1) begin
            r_lastGrant <= ARB_PORT_DBG;
        end else if (o_grant0) begin
            r_lastGrant <= ARB_PORT_CORE;
        end
    end

`else

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_badMaxWait
            $error("dmem_arb_grant: MAX_WAIT must be in 1..15");
        end
    endgenerate

    logic [3:0] r_waitCnt;
    logic       w_starve;

    assign w_starve = (r_waitCnt == MAX_WAIT_L);

    always_comb begin
        o_grant1 = i_p1_valid && (!i_p0_valid || w_starve);
        o_grant0 = i_p0_valid && !o_grant1;
    end

    // Counts consecutive cycles port 1 has waited; cleared on idle or acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (!i_p1_valid || o_grant1) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= satInc(r_waitCnt, MAX_WAIT_L);
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous DMEM with a fixed 1-cycle response.
// Define DMEM_ARB_RR_EN for round-robin arbitration (MAX_WAIT is then not a parameter).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
`ifndef DMEM_ARB_RR_EN
    ,
    parameter int MAX_WAIT   = 4
`endif
)(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [3:0]            p0_be,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [3:0]            p1_be,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic      w_grant0;
    logic      w_grant1;
    logic      r_rspPend;
    logic      r_rspIsRd;
    arb_port_e r_rspOwner;

`ifdef DMEM_ARB_RR_EN
    dmem_arb_grant u_grant (
`else
    dmem_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .i_p0_valid (p0_valid),
        .i_p1_valid (p1_valid),
        .o_grant0   (w_grant0),
        .o_grant1   (w_grant1)
    );

    assign p0_ready = w_grant0;
    assign p1_ready = w_grant1;

    // Idle memory bus is driven to all zeros so DMEM never sees stale fields.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant1) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_be    = p1_be;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (w_grant0) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_be    = p0_be;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    // One-deep response stage; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspPend  <= 1'b0;
            r_rspIsRd  <= 1'b0;
            r_rspOwner <= ARB_PORT_CORE;
        end else begin
            r_rspPend <= w_grant0 || w_grant1;
            if (w_grant1) begin
                r_rspOwner <= ARB_PORT_DBG;
                r_rspIsRd  <= !p1_we;
            end else if (w_grant0) begin
                r_rspOwner <= ARB_PORT_CORE;
                r_rspIsRd  <= !p0_we;
            end
        end
    end

    assign p0_rsp_valid = r_rspPend && (r_rspOwner == ARB_PORT_CORE);
    assign p1_rsp_valid = r_rspPend && (r_rspOwner == ARB_PORT_DBG);
    assign p0_rdata     = (p0_rsp_valid && r_rspIsRd) ? mem_rdata : '0;
    assign p1_rdata     = (p1_rsp_valid && r_rspIsRd) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus contention, back-to-back and reset sequences.
// Expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    typedef struct packed {
        logic          p0v;
        logic          p0we;
        logic [3:0]    p0be;
        logic [AW-1:0] p0addr;
        logic [DW-1:0] p0wdata;
        logic          p1v;
        logic          p1we;
        logic [3:0]    p1be;
        logic [AW-1:0] p1addr;
        logic [DW-1:0] p1wdata;
        logic [DW-1:0] memRd;
        logic          g0;
        logic          g1;
    } vec_t;

    typedef struct packed {
        logic valid;
        logic port;
        logic isRd;
    } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          p0_valid, p0_ready, p0_we, p0_rsp_valid;
    logic [3:0]    p0_be;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_valid, p1_ready, p1_we, p1_rsp_valid;
    logic [3:0]    p1_be;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int   checks = 0;
    int   errors = 0;
    rsp_t sbQ[$];
    vec_t vecs[8];

    dmem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW)
`ifndef DMEM_ARB_RR_EN
        ,
        .MAX_WAIT     (MW)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_we        (p0_we),
        .p0_be        (p0_be),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_we        (p1_we),
        .p1_be        (p1_be),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic p0v, input logic p0we, input logic [3:0] p0be,
        input logic [AW-1:0] p0addr, input logic [DW-1:0] p0wdata,
        input logic p1v, input logic p1we, input logic [3:0] p1be,
        input logic [AW-1:0] p1addr, input logic [DW-1:0] p1wdata,
        input logic [DW-1:0] memRd, input logic g0, input logic g1);
        vec_t v;
        v.p0v = p0v;  v.p0we = p0we;  v.p0be = p0be;  v.p0addr = p0addr;  v.p0wdata = p0wdata;
        v.p1v = p1v;  v.p1we = p1we;  v.p1be = p1be;  v.p1addr = p1addr;  v.p1wdata = p1wdata;
        v.memRd = memRd;  v.g0 = g0;  v.g1 = g1;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        p0_valid = v.p0v;  p0_we = v.p0we;  p0_be = v.p0be;  p0_addr = v.p0addr;  p0_wdata = v.p0wdata;
        p1_valid = v.p1v;  p1_we = v.p1we;  p1_be = v.p1be;  p1_addr = v.p1addr;  p1_wdata = v.p1wdata;
        mem_rdata = v.memRd;
    endtask

    // Compares the request side against the vector and the response side against the scoreboard.
    task automatic checkOutput(input vec_t v);
        rsp_t          e;
        logic          expWe;
        logic [3:0]    expBe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic          exp0, exp1;
        expWe = 1'b0;  expBe = '0;  expAddr = '0;  expWdata = '0;
        if (v.g1) begin
            expWe = v.p1we;  expBe = v.p1be;  expAddr = v.p1addr;  expWdata = v.p1wdata;
        end else if (v.g0) begin
            expWe = v.p0we;  expBe = v.p0be;  expAddr = v.p0addr;  expWdata = v.p0wdata;
        end
        checkVal("p0_ready", 32'(p0_ready), 32'(v.g0));
        checkVal("p1_ready", 32'(p1_ready), 32'(v.g1));
        checkVal("mem_en", 32'(mem_en), 32'(v.g0 | v.g1));
        checkVal("mem_we", 32'(mem_we), 32'(expWe));
        checkVal("mem_be", 32'(mem_be), 32'(expBe));
        checkVal("mem_addr", mem_addr, expAddr);
        checkVal("mem_wdata", mem_wdata, expWdata);
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry at %0t", $time);
            e = '0;
        end else begin
            e = sbQ.pop_front();
        end
        exp0 = e.valid && !e.port;
        exp1 = e.valid && e.port;
        checkVal("p0_rsp_valid", 32'(p0_rsp_valid), 32'(exp0));
        checkVal("p1_rsp_valid", 32'(p1_rsp_valid), 32'(exp1));
        checkVal("p0_rdata", p0_rdata, (exp0 && e.isRd) ? v.memRd : 32'h0);
        checkVal("p1_rdata", p1_rdata, (exp1 && e.isRd) ? v.memRd : 32'h0);
        e.valid = v.g0 | v.g1;
        e.port  = v.g1;
        e.isRd  = v.g1 ? !v.p1we : !v.p0we;
        sbQ.push_back(e);
    endtask

    task automatic runCycle(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset just after a clock edge, so any response accepted on that edge must vanish.
    task automatic resetDut();
        rst_n = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkVal("rst p0_ready", 32'(p0_ready), 32'h0);
        checkVal("rst p1_ready", 32'(p1_ready), 32'h0);
        checkVal("rst p0_rsp_valid", 32'(p0_rsp_valid), 32'h0);
        checkVal("rst p1_rsp_valid", 32'(p1_rsp_valid), 32'h0);
        checkVal("rst p0_rdata", p0_rdata, 32'h0);
        checkVal("rst p1_rdata", p1_rdata, 32'h0);
        checkVal("rst mem_en", 32'(mem_en), 32'h0);
        checkVal("rst mem_we", 32'(mem_we), 32'h0);
        checkVal("rst mem_be", 32'(mem_be), 32'h0);
        checkVal("rst mem_addr", mem_addr, 32'h0);
        checkVal("rst mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbQ.delete();
        sbQ.push_back('0);
    endtask

    // Both ports held valid; p1 keeps one stable write request throughout.
    task automatic runContention(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = mkVec(1'b1, 1'b0, 4'hF, 32'h200 + 32'(i) * 4, 32'h0,
                      1'b1, 1'b1, 4'hF, 32'h300, 32'h5A5A_1234,
                      32'h7700_0000 + 32'(i), 1'b0, 1'b0);
`ifdef DMEM_ARB_RR_EN
            v.g1 = ((i % 2) == 1);
`else
            v.g1 = ((i % (MW + 1)) == MW);
`endif
            v.g0 = !v.g1;
            runCycle(v);
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        p0_valid = 1'b0;  p0_we = 1'b0;  p0_be = '0;  p0_addr = '0;  p0_wdata = '0;
        p1_valid = 1'b0;  p1_we = 1'b0;  p1_be = '0;  p1_addr = '0;  p1_wdata = '0;
        mem_rdata = '0;

        vecs[0] = mkVec(1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 4'h3, 32'h999, 32'h1111, 32'h0,         1, 0);
        vecs[1] = mkVec(0, 1, 4'h5, 32'h44, 32'h77,       0, 0, 4'h0, 32'h0,   32'h0,    32'hDEADBEEF,  0, 0);
        vecs[2] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 1, 4'h4, 32'h20,  32'h00AB0000, 32'h0,     0, 1);
        vecs[3] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 32'h0,   32'h0,    32'h12345678,  0, 0);
        vecs[4] = mkVec(1, 1, 4'hF, 32'hFFFF_FFFC, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0,    1, 0);
        vecs[5] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'hF, 32'h80,  32'h0,    32'h11111111,  0, 1);
        vecs[6] = mkVec(1, 0, 4'hF, 32'h84, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,    32'h22222222,  1, 0);
        vecs[7] = mkVec(0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 32'h0,   32'h0,    32'h33333333,  0, 0);

        @(posedge clk);
        #1;
        resetDut();

        for (int i = 0; i < 8; i++) begin
            runCycle(vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            v = mkVec(1, 0, 4'hF, 32'h100 + 32'(i) * 4, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0,
                      32'hB000_0000 + 32'(i), 1, 0);
            runCycle(v);
        end
        runCycle(mkVec(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hB000_0008, 0, 0));

        resetDut();
        runContention(15);

        resetDut();
        runContention(MW);
        resetDut();
        runContention(2 * (MW + 1));

        runCycle(mkVec(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h4444_4444, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (DMEM) between two requesters.
  - Port 0: the core's LSU path.
  - Port 1: a debug/DMA port.
- Uses a valid/ready request handshake and a fixed 1-cycle response.
- Sits between the LSU/debug masters and DMEM.
- Port 0 has fixed priority; a starvation counter guarantees port 1 progress.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches `DMEM_ADDR_WIDTH).
- DATA_WIDTH, 32, data width (matches `DMEM_DATA_WIDTH).
- MAX_WAIT, 4, consecutive stalled cycles of port 1 before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_we  in  1  1=write, 0=read
- p0_be  in  4  byte enables
- p0_addr  in  ADDR_WIDTH  word-aligned address
- p0_wdata  in  DATA_WIDTH  write data
- p0_rsp_valid  out  1  response for port 0
- p0_rdata  out  DATA_WIDTH  read data, 0 for write responses
- p1_valid, p1_ready, p1_we, p1_be, p1_addr, p1_wdata, p1_rsp_valid, p1_rdata  same as port 0, for port 1
- mem_en  out  1  DMEM access strobe
- mem_we  out  1  DMEM write
- mem_be  out  4  DMEM byte enables
- mem_addr  out  ADDR_WIDTH  DMEM address
- mem_wdata  out  DATA_WIDTH  DMEM write data
- mem_rdata  in  DATA_WIDTH  DMEM read data, valid 1 cycle after mem_en && !mem_we

Behaviour:
- Handshake:
  - A request is accepted when valid && ready in the same cycle.
  - A requester holds all request fields stable while valid && !ready.
  - A requester must not drop valid before acceptance.
- Arbitration (combinational, per cycle):
  - grant1 = p1_valid && (!p0_valid || starve).
  - grant0 = p0_valid && !grant1.
  - pX_ready = grantX. At most one ready is high per cycle.
- Memory drive:
  - mem_en = grant0 || grant1.
  - mem_we, mem_be, mem_addr and mem_wdata are muxed from the granted port.
  - When mem_en=0: mem_we=0, mem_be=0, remaining fields 0.
- Starvation counter wait_cnt (4 bits, registered):
  - Clears when !p1_valid or when p1 is accepted.
  - Otherwise increments, saturating at MAX_WAIT.
  - starve = (wait_cnt == MAX_WAIT).
- Response pipeline (one stage, registered): rsp_owner, rsp_pend, rsp_is_rd.
  - In the cycle after acceptance, owner's rsp_valid=1 for exactly one cycle.
  - rdata = mem_rdata for reads, 0 for writes.
  - The non-owner's rdata stays 0.
- Throughput: back-to-back accepts every cycle; no response backpressure. Requesters must always sink responses.
- Latency: request accept to rsp_valid = 1 cycle, for reads and writes.
- Reset values: all outputs 0; wait_cnt=0; rsp_pend=0.
- Reset mid-operation: a pending response is dropped and no rsp_valid is issued. After deassertion, arbitration restarts with wait_cnt=0.
- Simultaneous events:
  - Both valid and !starve -> port 0 wins.
  - Both valid and starve -> port 1 wins, and wait_cnt clears next cycle.
- Parameter guard: MAX_WAIT outside 1..15 is an elaboration error.

Optional Feature:
- DMEM_ARB_RR_EN
  - Defined: round-robin arbitration replaces fixed priority + starvation.
    - A registered last_grant bit is set to the port granted on each accept; reset value is 1, so port 0 is favoured first.
    - When both ports are valid, the port != last_grant wins.
    - wait_cnt and MAX_WAIT are unused and removed.
  - Undefined: fixed priority with starvation counter, as above.

Decomposition:
- Shared in defines.vh: `DMEM_ADDR_WIDTH and `DMEM_DATA_WIDTH, plus new constants `ARB_PORT_CORE=1'b0 and `ARB_PORT_DBG=1'b1.
- One natural sub-module, dmem_arb_grant, owns:
  - grant logic
  - wait_cnt or last_grant
- The top level keeps the memory mux and the response pipeline.

Test Plan:
- Single read:
  - Stimulus: p0 reads addr 0x10, mem_rdata=0xDEADBEEF next cycle.
  - Response: p0_ready=1 in cycle 0; p0_rsp_valid=1 with p0_rdata=0xDEADBEEF in cycle 1; p1 signals 0.
- Contention:
  - Stimulus: p0 and p1 both valid continuously, MAX_WAIT=4.
  - Response: p0 accepted in cycles 0-3; p1 accepted in cycle 4; p0 in cycle 5; pattern repeats with period 5.
- Write:
  - Stimulus: p1 writes be=4'b0100, wdata=0x00AB0000 at 0x20, p0 idle.
  - Response: mem_we=1, mem_be=4'b0100 same cycle; p1_rsp_valid=1 next cycle with p1_rdata=0.
- Back-to-back:
  - Stimulus: p0 issues 8 reads on consecutive cycles.
  - Response: 8 accepts and 8 responses, each 1 cycle later and in order.
- Reset mid-op:
  - Stimulus: assert rst_n=0 in the cycle after a p0 read is accepted.
  - Response: no p0_rsp_valid; all outputs 0 immediately; wait_cnt=0.
- RR mode (DMEM_ARB_RR_EN):
  - Stimulus: both ports continuously valid.
  - Response: grants alternate p0, p1, p0, p1… starting with p0.
